// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS MEM stage: access-size codes, FSM states and
// byte-lane write-enable decode.
package mem_stage_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SizeByte: lane_en = 4'b0001 << off;
      SizeHalf: lane_en = off[1] ? 4'b1100 : 4'b0011;
      default:  lane_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Data memory of DEPTH 32-bit words with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module dmem_bytelane #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_lat.sv
// MIPS MEM stage with byte/half/word access, configurable load latency with stall,
// WB->MEM store-data forwarding, misalignment flagging and the MEM/WB register.
module mem_stage_lat
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_write_reg,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [4:0]        wb_write_reg,
  output logic              wb_misaligned
);

  localparam int unsigned Aw = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, wb_misaligned_q;
  logic [31:0] wb_alu_result_q, wb_read_data_q;
  logic [4:0]  wb_write_reg_q;

  logic [Aw-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          mis_addr, mis, load_go, fwd_hit;
  logic [31:0]   wb_result, store_src, store_lane, rd_word, load_ext;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [3:0]    be;
  logic          unused_addr_hi;

  assign word_idx       = ex_alu_result[Aw+1:2];
  assign byte_off       = ex_alu_result[1:0];
  assign unused_addr_hi = ^ex_alu_result[DATA_W-1:Aw+2];

  always_comb begin
    case (ex_size)
      SizeByte: mis_addr = 1'b0;
      SizeHalf: mis_addr = byte_off[0];
      SizeWord: mis_addr = (byte_off != 2'b00);
      default:  mis_addr = (byte_off != 2'b00);
    endcase
  end

  // Only memory accesses can be misaligned; ALU results with odd low bits are fine.
  assign mis     = (ex_mem_read | ex_mem_write) & mis_addr;
  assign load_go = ex_valid & ex_mem_read & ~mis;

  assign wb_result = wb_mem_to_reg_q ? wb_read_data_q : wb_alu_result_q;
  assign fwd_hit   = wb_valid_q & wb_reg_write_q & (wb_write_reg_q != 5'd0) &
                     (wb_write_reg_q == ex_rt);
  assign store_src = fwd_hit ? wb_result : ex_store_data;

  always_comb begin
    case (ex_size)
      SizeByte: store_lane = {4{store_src[7:0]}};
      SizeHalf: store_lane = {2{store_src[15:0]}};
      default:  store_lane = store_src;
    endcase
  end

  // A store commits only on the edge where the entry is accepted.
  assign be = (ex_valid & ex_mem_write & ~mis & ~stall) ? lane_en(ex_size, byte_off) : 4'b0000;

  dmem_bytelane #(
    .DEPTH (DEPTH),
    .AddrW (Aw)
  ) u_dmem (
    .clk_i   (clk),
    .be_i    (be),
    .addr_i  (word_idx),
    .wdata_i (store_lane),
    .rdata_o (rd_word)
  );

  assign lane_byte = rd_word[8*byte_off +: 8];
  assign lane_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (ex_size)
      SizeByte: load_ext = {{24{~ex_unsigned & lane_byte[7]}}, lane_byte};
      SizeHalf: load_ext = {{16{~ex_unsigned & lane_half[15]}}, lane_half};
      default:  load_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_go && RD_LAT > 0) begin
          stall   = 1'b1;
          state_d = StWait;
          cnt_d   = 2'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q != 2'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!stall && !ex_valid)) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_write_reg_q  <= '0;
      wb_misaligned_q <= 1'b0;
    end else if (stall) begin
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q      <= 1'b1;
      wb_reg_write_q  <= ex_reg_write & ~mis;
      wb_mem_to_reg_q <= ex_mem_to_reg;
      wb_alu_result_q <= ex_alu_result;
      wb_read_data_q  <= (ex_mem_read && !mis) ? load_ext : 32'd0;
      wb_write_reg_q  <= ex_write_reg;
      wb_misaligned_q <= mis;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Bench for mem_stage_lat: vector table with scoreboard on a zero-latency instance,
// hand sequences for stall timing and reset-during-wait on an RD_LAT=2 instance.
module tb_mem_stage_lat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rt, ex_write_reg;

  logic        s0, v0, rw0, m2r0, mis0;
  logic [31:0] alu0, rd0;
  logic [4:0]  wr0;
  logic        s2, v2, rw2, m2r2, mis2;
  logic [31:0] alu2, rd2;
  logic [4:0]  wr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lat #(.DATA_W(32), .DEPTH(256), .RD_LAT(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .stall(s0), .wb_valid(v0), .wb_reg_write(rw0), .wb_mem_to_reg(m2r0),
    .wb_alu_result(alu0), .wb_read_data(rd0), .wb_write_reg(wr0), .wb_misaligned(mis0)
  );

  mem_stage_lat #(.DATA_W(32), .DEPTH(256), .RD_LAT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .stall(s2), .wb_valid(v2), .wb_reg_write(rw2), .wb_mem_to_reg(m2r2),
    .wb_alu_result(alu2), .wb_read_data(rd2), .wb_write_reg(wr2), .wb_misaligned(mis2)
  );

  typedef struct packed {
    logic        vld, rw, m2r, rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, sd;
    logic [4:0]  rt, wreg;
    logic        e_valid, e_rw, e_mis;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct packed {
    logic        valid, rw, m2r, mis;
    logic [31:0] alu, rdata;
    logic [4:0]  wreg;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[22];

  function automatic vec_t mk(input logic vld, rw, m2r, rd, wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, sd,
                              input logic [4:0] rt, wreg, input logic e_valid, e_rw, e_mis,
                              input logic [31:0] e_rdata);
    vec_t v;
    v = '{vld, rw, m2r, rd, wr, size, uns, addr, sd, rt, wreg, e_valid, e_rw, e_mis, e_rdata};
    return v;
  endfunction

  function automatic vec_t ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                              input logic [4:0] wreg, input logic [31:0] e_rdata);
    return mk(1, 1, 1, 1, 0, size, uns, addr, 32'h0, 5'd0, wreg, 1, 1, 0, e_rdata);
  endfunction

  function automatic vec_t st(input logic [1:0] size, input logic [31:0] addr, sd,
                              input logic [4:0] rt);
    return mk(1, 0, 0, 0, 1, size, 1'b0, addr, sd, rt, 5'd0, 1, 0, 0, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    ex_valid      = v.vld;
    ex_reg_write  = v.rw;
    ex_mem_to_reg = v.m2r;
    ex_mem_read   = v.rd;
    ex_mem_write  = v.wr;
    ex_size       = v.size;
    ex_unsigned   = v.uns;
    ex_alu_result = v.addr;
    ex_store_data = v.sd;
    ex_rt         = v.rt;
    ex_write_reg  = v.wreg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a load into the RD_LAT=2 instance and follow it to completion with a cycle budget.
  task automatic lat_load(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    int  stalls;
    bit  done;
    stalls = 0;
    done   = 1'b0;
    set_in(ld(2'b10, 1'b0, addr, 5'd7, 32'h0));
    for (int c = 0; c < 8 && !done; c++) begin
      #1;
      if (s2) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) chk({tag, " wb_valid in stall"}, v2, 1'b0);
    end
    chk({tag, " completed"}, done, 1'b1);
    chk({tag, " stall cycles"}, stalls, 2);
    chk({tag, " wb_valid"}, v2, 1'b1);
    chk({tag, " wb_read_data"}, rd2, exp);
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, g;

    vecs[0]  = st(2'b10, 32'h10, 32'h11223344, 5'd3);
    vecs[1]  = ld(2'b10, 1'b0, 32'h10, 5'd5, 32'h11223344);
    vecs[2]  = st(2'b00, 32'h13, 32'h000000AB, 5'd7);
    vecs[3]  = ld(2'b00, 1'b0, 32'h13, 5'd6, 32'hFFFFFFAB);
    vecs[4]  = ld(2'b00, 1'b1, 32'h13, 5'd6, 32'h000000AB);
    vecs[5]  = ld(2'b10, 1'b0, 32'h10, 5'd5, 32'hAB223344);
    vecs[6]  = st(2'b10, 32'h20, 32'h0, 5'd5);
    vecs[7]  = ld(2'b10, 1'b0, 32'h20, 5'd9, 32'hAB223344);
    vecs[8]  = st(2'b01, 32'h16, 32'h1234BEEF, 5'd11);
    vecs[9]  = ld(2'b01, 1'b1, 32'h16, 5'd12, 32'h0000BEEF);
    vecs[10] = ld(2'b01, 1'b0, 32'h16, 5'd12, 32'hFFFFBEEF);
    vecs[11] = mk(1, 1, 1, 1, 0, 2'b01, 0, 32'h21, 32'h0, 5'd0, 5'd13, 1, 0, 1, 32'h0);
    vecs[12] = mk(1, 0, 0, 0, 1, 2'b10, 0, 32'h22, 32'hDEADBEEF, 5'd14, 5'd0, 1, 0, 1, 32'h0);
    vecs[13] = mk(0, 0, 0, 0, 1, 2'b10, 0, 32'h20, 32'hFFFFFFFF, 5'd0, 5'd0, 0, 0, 0, 32'h0);
    vecs[14] = ld(2'b10, 1'b0, 32'h20, 5'd9, 32'hAB223344);
    vecs[15] = mk(1, 1, 1, 1, 1, 2'b10, 0, 32'h10, 32'h55667788, 5'd15, 5'd4, 1, 1, 0,
                  32'hAB223344);
    vecs[16] = ld(2'b10, 1'b0, 32'h10, 5'd4, 32'h55667788);
    vecs[17] = ld(2'b00, 1'b0, 32'h11, 5'd4, 32'h00000077);
    vecs[18] = mk(1, 1, 0, 0, 0, 2'b01, 0, 32'h3, 32'h0, 5'd0, 5'd2, 1, 1, 0, 32'h0);
    vecs[19] = mk(1, 1, 0, 0, 0, 2'b10, 0, 32'h99, 32'h0, 5'd0, 5'd0, 1, 1, 0, 32'h0);
    vecs[20] = st(2'b10, 32'h40, 32'h12345678, 5'd0);
    vecs[21] = ld(2'b10, 1'b0, 32'h40, 5'd3, 32'h12345678);

    rst_n = 1'b0;
    set_in('0);
    step();
    step();
    chk("reset d0 wb_valid", v0, 1'b0);
    chk("reset d0 wb_read_data", rd0, 32'h0);
    chk("reset d0 wb_alu_result", alu0, 32'h0);
    chk("reset d0 stall", s0, 1'b0);
    chk("reset d2 wb_valid", v2, 1'b0);
    chk("reset d2 stall", s2, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i]);
      e.valid = vecs[i].e_valid;
      e.rw    = vecs[i].e_rw;
      e.m2r   = vecs[i].vld & vecs[i].m2r;
      e.mis   = vecs[i].e_mis;
      e.alu   = vecs[i].vld ? vecs[i].addr : 32'h0;
      e.rdata = vecs[i].e_rdata;
      e.wreg  = vecs[i].vld ? vecs[i].wreg : 5'd0;
      sb_q.push_back(e);
      #1;
      chk($sformatf("v%0d stall", i), s0, 1'b0);
      step();
      g = '{v0, rw0, m2r0, mis0, alu0, rd0, wr0};
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d wb_valid", i), g.valid, e.valid);
        chk($sformatf("v%0d wb_reg_write", i), g.rw, e.rw);
        chk($sformatf("v%0d wb_mem_to_reg", i), g.m2r, e.m2r);
        chk($sformatf("v%0d wb_misaligned", i), g.mis, e.mis);
        chk($sformatf("v%0d wb_alu_result", i), g.alu, e.alu);
        chk($sformatf("v%0d wb_read_data", i), g.rdata, e.rdata);
        chk($sformatf("v%0d wb_write_reg", i), g.wreg, e.wreg);
      end
    end

    // RD_LAT=2 instance: fresh start, store then stalled load.
    set_in('0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_in(st(2'b10, 32'h30, 32'hCAFEF00D, 5'd1));
    #1;
    chk("lat store stall", s2, 1'b0);
    step();
    lat_load(32'h30, 32'hCAFEF00D, "lat lw");

    set_in(mk(1, 1, 1, 1, 0, 2'b01, 0, 32'h31, 32'h0, 5'd0, 5'd8, 1, 0, 1, 32'h0));
    #1;
    chk("lat misaligned stall", s2, 1'b0);
    step();
    chk("lat misaligned flag", mis2, 1'b1);
    chk("lat misaligned reg_write", rw2, 1'b0);

    // Reset while the load is waiting.
    set_in(ld(2'b10, 1'b0, 32'h30, 5'd7, 32'h0));
    #1;
    chk("rstwait first stall", s2, 1'b1);
    step();
    chk("rstwait in wait stall", s2, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    ex_valid = 1'b0;
    #1;
    chk("rstwait stall after reset", s2, 1'b0);
    chk("rstwait wb_valid after reset", v2, 1'b0);
    step();
    lat_load(32'h30, 32'hCAFEF00D, "post-reset lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
